// File: rtl/sad_min_tree.sv
// sad_min_tree: pipelined SAD adder tree with running-minimum search over a motion window.
// Ports: clk, rst_n (async active-low); start begins a search; ad_valid/ad carry the
// MACRO_DIM^2 absolute-difference bytes of one candidate; busy is high while searching or
// draining; cur_valid/cur_sad expose each candidate SAD; done pulses once when
// best_sad/best_x/best_y are final.
module sad_min_tree #(
  parameter int MACRO_DIM = 16,
  parameter int SEARCH_DIM = 48,
  localparam int N = MACRO_DIM * MACRO_DIM,
  localparam int P = SEARCH_DIM - MACRO_DIM + 1,
  localparam int LAT = $clog2(MACRO_DIM),
  localparam int SAD_W = 8 + 2 * $clog2(MACRO_DIM),
  localparam int MV_W = $clog2(P)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ad_valid,
  input  logic [8*N-1:0]   ad,
  output logic             busy,
  output logic             cur_valid,
  output logic [SAD_W-1:0] cur_sad,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [MV_W-1:0]  best_x,
  output logic [MV_W-1:0]  best_y
);
  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [MV_W-1:0] cand_x, cand_y;
  logic [LAT-1:0] v;
  logic [MV_W-1:0] tx [LAT];
  logic [MV_W-1:0] ty [LAT];
  logic go, acc, last, x_wrap;
  assign go = start && (state == IDLE || state == DONE);
  assign acc = ad_valid && state == SEARCH;
  assign x_wrap = cand_x == MV_W'(P - 1);
  assign last = acc && x_wrap && cand_y == MV_W'(P - 1);
  assign busy = state == SEARCH || state == DRAIN;
  assign cur_valid = v[LAT-1];
  // DRAIN ends once only the compare-stage entry (if any) is left; it is folded in on this edge.
  always_comb
    state_nx = go ? SEARCH :
               last ? DRAIN :
               (state == DRAIN && v[LAT-2:0] == '0) ? DONE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= state == DRAIN && state_nx == DONE;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cand_x <= '0;
      cand_y <= '0;
    end else if (go) begin
      cand_x <= '0;
      cand_y <= '0;
    end else if (acc) begin
      cand_x <= x_wrap ? '0 : cand_x + 1'b1;
      cand_y <= x_wrap ? cand_y + 1'b1 : cand_y;
    end
  // Valid bit and window tag travel in lockstep with the tree registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) begin
        tx[i] <= '0;
        ty[i] <= '0;
      end
    end else begin
      v <= {v[LAT-2:0], acc};
      tx[0] <= cand_x;
      ty[0] <= cand_y;
      for (int i = 1; i < LAT; i++) begin
        tx[i] <= tx[i-1];
        ty[i] <= ty[i-1];
      end
    end
  // Each register stage folds two binary add levels: four inputs into one, two bits wider.
  for (genvar s = 0; s < LAT; s++) begin : g_s
    localparam int IW = 8 + 2 * s;
    localparam int IN = N >> (2 * s);
    localparam int ON = IN / 4;
    localparam int OW = IW + 2;
    logic [IN*IW-1:0] din;
    logic [ON*OW-1:0] sum, q;
    if (s == 0) begin : g_in
      assign din = ad;
    end else begin : g_in
      assign din = g_s[s-1].q;
    end
    for (genvar o = 0; o < ON; o++) begin : g_o
      logic [IW:0] a, b;
      assign a = {1'b0, din[(4*o)*IW +: IW]} + {1'b0, din[(4*o+1)*IW +: IW]};
      assign b = {1'b0, din[(4*o+2)*IW +: IW]} + {1'b0, din[(4*o+3)*IW +: IW]};
      assign sum[o*OW +: OW] = {1'b0, a} + {1'b0, b};
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else q <= sum;
  end
  assign cur_sad = g_s[LAT-1].q;
  // Strict less-than keeps the earliest candidate in scan order on ties.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      best_sad <= '1;
      best_x <= '0;
      best_y <= '0;
    end else if (go) begin
      best_sad <= '1;
      best_x <= '0;
      best_y <= '0;
    end else if (cur_valid && cur_sad < best_sad) begin
      best_sad <= cur_sad;
      best_x <= tx[LAT-1];
      best_y <= ty[LAT-1];
    end
endmodule

// File: tb/tb_sad_min_tree.sv
// tb_sad_min_tree: table-driven searches with a scoreboard of per-candidate SADs.
module tb_sad_min_tree;
  localparam int MD = 16, SD = 48, P = SD - MD + 1, N = MD * MD, SW = 16, MW = 6;
  logic clk = 0, rst_n = 0, start = 0, ad_valid = 0;
  logic [8*N-1:0] ad = '0;
  logic busy, cur_valid, done;
  logic [SW-1:0] cur_sad, best_sad;
  logic [MW-1:0] best_x, best_y;
  sad_min_tree #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ad_valid(ad_valid), .ad(ad),
    .busy(busy), .cur_valid(cur_valid), .cur_sad(cur_sad), .done(done),
    .best_sad(best_sad), .best_x(best_x), .best_y(best_y)
  );
  always #5 clk = ~clk;
  typedef struct {
    int base;
    int sx1, sy1, sv1, sx2, sy2, sv2;
    bit rnd, misuse;
    int exp_sad, exp_x, exp_y;
  } vec_t;
  typedef struct {int sad; int cyc;} sb_t;
  sb_t q[$];
  int compared = 0, mismatched = 0, cyc = 0, ncur = 0, ndone = 0, done_cyc = -100;
  logic done_busy = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (cur_valid) begin
      ncur++;
      if (q.size() == 0) chk("unexpected_cur_valid", 1, 0);
      else begin
        sb_t e;
        e = q.pop_front();
        chk("cur_sad", cur_sad, e.sad);
        chk("cur_latency", cyc - e.cyc, 4);
      end
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
      done_busy = busy;
    end
  end
  task automatic gen(input vec_t v, input int x, input int y, output logic [8*N-1:0] d, output int s);
    int b;
    s = 0;
    d = '0;
    for (int j = 0; j < N; j++) begin
      b = v.rnd ? int'($urandom_range(0, 255)) :
          (x == v.sx1 && y == v.sy1) ? v.sv1 :
          (x == v.sx2 && y == v.sy2) ? v.sv2 : v.base;
      d[8*j +: 8] = b[7:0];
      s += b;
    end
  endtask
  task automatic run_search(input vec_t v, input int ncand, output int lc, output int ms, output int mx, output int my);
    logic [8*N-1:0] d;
    int s, x, y;
    ms = 'hFFFF; mx = 0; my = 0; lc = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (int k = 0; k < ncand; k++) begin
      x = k % P;
      y = k / P;
      if (v.rnd) while ($urandom_range(0, 1) == 1) begin
        ad_valid = 0;
        @(negedge clk);
      end
      if (k == 0) chk("busy_in_search", busy, 1);
      gen(v, x, y, d, s);
      if (s < ms) begin ms = s; mx = x; my = y; end
      ad = d;
      ad_valid = 1;
      start = v.misuse && k == 100;
      q.push_back('{s, cyc});
      lc = cyc;
      @(negedge clk);
    end
    ad_valid = 0;
    start = 0;
  endtask
  task automatic full(input vec_t v);
    int lc, ms, mx, my, nd0, t;
    nd0 = ndone;
    ncur = 0;
    run_search(v, P * P, lc, ms, mx, my);
    t = 0;
    while (ndone == nd0 && t < 20) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("done_pulses", ndone - nd0, 1);
    chk("done_latency", done_cyc - lc, 5);
    chk("busy_at_done", done_busy, 0);
    chk("cur_valid_count", ncur, P * P);
    chk("scoreboard_empty", q.size(), 0);
    chk("best_sad", best_sad, v.rnd ? ms : v.exp_sad);
    chk("best_x", best_x, v.rnd ? mx : v.exp_x);
    chk("best_y", best_y, v.rnd ? my : v.exp_y);
  endtask
  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_cur_valid"}, cur_valid, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_cur_sad"}, cur_sad, 0);
    chk({pfx, "_best_sad"}, best_sad, 'hFFFF);
    chk({pfx, "_best_x"}, best_x, 0);
    chk({pfx, "_best_y"}, best_y, 0);
  endtask
  initial begin
    vec_t tbl[5];
    int lc, ms, mx, my, nd0, nc0;
    tbl[0] = '{10, 5, 7, 1, -1, -1, 0, 0, 0, 256, 5, 7};
    tbl[1] = '{1, 3, 0, 0, 0, 2, 0, 0, 0, 0, 3, 0};
    tbl[2] = '{255, -1, -1, 0, -1, -1, 0, 0, 0, 65280, 0, 0};
    tbl[3] = '{0, -1, -1, 0, -1, -1, 0, 1, 0, 0, 0, 0};
    tbl[4] = '{20, 32, 32, 3, -1, -1, 0, 0, 1, 768, 32, 32};
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1;
    @(negedge clk);
    ad = '0;
    ad_valid = 1;
    repeat (3) @(negedge clk);
    ad_valid = 0;
    repeat (6) @(negedge clk);
    chk("idle_ignore_cur", ncur, 0);
    chk("idle_best_sad", best_sad, 'hFFFF);
    for (int i = 0; i < 5; i++) begin
      full(tbl[i]);
      if (tbl[i].misuse) begin
        nc0 = ncur;
        nd0 = ndone;
        ad = '0;
        ad_valid = 1;
        repeat (3) @(negedge clk);
        ad_valid = 0;
        repeat (6) @(negedge clk);
        chk("done_ignore_cur", ncur, nc0);
        chk("done_no_repulse", ndone, nd0);
        chk("done_hold_sad", best_sad, 768);
        chk("done_hold_x", best_x, 32);
      end
    end
    nd0 = ndone;
    run_search(tbl[0], 500, lc, ms, mx, my);
    rst_n = 0;
    #1;
    chk_reset_vals("midreset");
    q.delete();
    repeat (10) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("midreset_no_done", ndone, nd0);
    full(tbl[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
